muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
//
// Implements MULT, MULTU, DIV, DIVU (one radix-2 step per clock) and
// MTHI/MTLO. HI and LO are read continuously by the pipeline for MFHI/MFLO.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        launch request, sampled only in IDLE
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a        multiplicand / dividend
//   src_b        multiplier / divisor
//   cancel       abort in-flight operation (exception flush)
//   hi_we/lo_we  MTHI/MTLO write enables (honoured only while not busy)
//   wdata        MTHI/MTLO data
//   busy         operation in flight
//   done         one-cycle pulse; new HI/LO visible in this cycle
//   div_by_zero  valid with done; divide with src_b == 0
//   hi/lo        HI and LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;

    // Operation context captured at accept
    logic             is_div;
    logic             neg_res;   // negate product / quotient
    logic             neg_rem;   // negate remainder (dividend was negative)
    logic             b_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // acc: full product for multiply; low half holds dividend/quotient for divide
    logic [W2-1:0]    acc;
    logic [WIDTH:0]   rem;

    logic             sign_a;
    logic             sign_b;
    logic             is_signed;

    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [W2-1:0] cond_neg2(input logic [W2-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign is_signed = ~op[0];
    assign sign_a    = $signed(src_a) < 0;
    assign sign_b    = $signed(src_b) < 0;

    always_comb begin
        mul_sum   = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        // Shift in the next dividend bit; a set rem[WIDTH] means the trial
        // value exceeds any divisor, so the subtraction always succeeds.
        div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
        div_ge    = rem[WIDTH] | (div_shift >= {1'b0, mag_b});
        div_diff  = div_shift - {1'b0, mag_b};
        rem_next  = div_ge ? div_diff : div_shift;
        quo_next  = {acc[WIDTH-2:0], div_ge};
        prod_fix  = cond_neg2(acc, neg_res);
        quo_fix   = cond_neg(acc[WIDTH-1:0], neg_res);
        rem_fix   = cond_neg(rem[WIDTH-1:0], neg_rem);
    end

    // Datapath: operand capture at accept, one radix-2 step per RUN cycle
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start && !cancel) begin
                    is_div  <= op[1];
                    neg_res <= is_signed & (sign_a ^ sign_b);
                    neg_rem <= is_signed & sign_a;
                    b_zero  <= (src_b == '0);
                    mag_a   <= cond_neg(src_a, is_signed & sign_a);
                    mag_b   <= cond_neg(src_b, is_signed & sign_b);
                    acc     <= op[1] ? {{WIDTH{1'b0}}, cond_neg(src_a, is_signed & sign_a)}
                                     : {{WIDTH{1'b0}}, cond_neg(src_b, is_signed & sign_b)};
                    rem     <= '0;
                end
            end
            RUN: begin
                if (!cancel) begin
                    if (is_div) begin
                        acc[WIDTH-1:0] <= quo_next;
                        rem            <= rem_next;
                    end else begin
                        acc <= mul_next;
                    end
                end
            end
            default: ;
        endcase
    end

    // Control FSM and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (!busy && hi_we) hi <= wdata;
            if (!busy && lo_we) lo <= wdata;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                        if (cnt == CNT_LAST) state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (is_div) begin
                            div_by_zero <= b_zero;
                            // Divide by zero leaves HI/LO untouched
                            if (!b_zero) begin
                                lo <= quo_fix;
                                hi <= rem_fix;
                            end
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: WIDTH=32 and WIDTH=8 instances, directed
// vectors, expected results queued at issue and checked by per-DUT monitors.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // WIDTH=32 instance signals
    logic        start_a = 1'b0;
    logic [1:0]  op_a = 2'b00;
    logic [31:0] a_a = '0;
    logic [31:0] b_a = '0;
    logic        cancel_a = 1'b0;
    logic        hi_we_a = 1'b0;
    logic        lo_we_a = 1'b0;
    logic [31:0] wdata_a = '0;
    logic        busy_a, done_a, dbz_a;
    logic [31:0] hi_a, lo_a;

    // WIDTH=8 instance signals
    logic        start_b = 1'b0;
    logic [1:0]  op_b = 2'b00;
    logic [7:0]  a_b = '0;
    logic [7:0]  b_b = '0;
    logic        cancel_b = 1'b0;
    logic        hi_we_b = 1'b0;
    logic        lo_we_b = 1'b0;
    logic [7:0]  wdata_b = '0;
    logic        busy_b, done_b, dbz_b;
    logic [7:0]  hi_b, lo_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    muldiv_unit #(.WIDTH(32)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .op(op_a),
        .src_a(a_a), .src_b(b_a), .cancel(cancel_a),
        .hi_we(hi_we_a), .lo_we(lo_we_a), .wdata(wdata_a),
        .busy(busy_a), .done(done_a), .div_by_zero(dbz_a),
        .hi(hi_a), .lo(lo_a)
    );

    muldiv_unit #(.WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .op(op_b),
        .src_a(a_b), .src_b(b_b), .cancel(cancel_b),
        .hi_we(hi_we_b), .lo_we(lo_we_b), .wdata(wdata_b),
        .busy(busy_b), .done(done_b), .div_by_zero(dbz_b),
        .hi(hi_b), .lo(lo_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_a(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input bit push, input logic [31:0] eh, input logic [31:0] el,
                           input logic ed);
        exp_t e;
        if (push) begin
            e.hi = eh; e.lo = el; e.dbz = ed; e.cyc = cyc + 1;
            q_a.push_back(e);
        end
        op_a = o; a_a = x; b_a = y; start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic issue_b(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] eh, input logic [7:0] el);
        exp_t e;
        e.hi = {24'h0, eh}; e.lo = {24'h0, el}; e.dbz = 1'b0; e.cyc = cyc + 1;
        q_b.push_back(e);
        op_b = o; a_b = x; b_b = y; start_b = 1'b1;
        tick();
        start_b = 1'b0;
    endtask

    // Returns the number of cycles busy stayed high after the accept edge
    task automatic wait_idle_a(output int n);
        n = 0;
        while (busy_a && n < 200) begin
            tick();
            n++;
        end
        if (busy_a) check("timeout_a", 64'(busy_a), 64'(0));
    endtask

    task automatic wait_idle_b(output int n);
        n = 0;
        while (busy_b && n < 200) begin
            tick();
            n++;
        end
        if (busy_b) check("timeout_b", 64'(busy_b), 64'(0));
    endtask

    // Monitors: pop and compare whenever a DUT presents done
    always @(negedge clk) begin
        if (done_a) begin
            if (q_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done_a: done seen at cycle %0d with nothing outstanding", cyc);
            end else begin
                ea = q_a.pop_front();
                check("hi_a", 64'(hi_a), 64'(ea.hi));
                check("lo_a", 64'(lo_a), 64'(ea.lo));
                check("dbz_a", 64'(dbz_a), 64'(ea.dbz));
                check("latency_a", 64'(cyc - ea.cyc), 64'(33));
                check("busy_at_done_a", 64'(busy_a), 64'(0));
            end
        end
    end

    always @(negedge clk) begin
        if (done_b) begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done_b: done seen at cycle %0d with nothing outstanding", cyc);
            end else begin
                eb = q_b.pop_front();
                check("hi_b", 64'(hi_b), 64'(eb.hi));
                check("lo_b", 64'(lo_b), 64'(eb.lo));
                check("dbz_b", 64'(dbz_b), 64'(eb.dbz));
                check("latency_b", 64'(cyc - eb.cyc), 64'(9));
            end
        end
    end

    initial begin
        int n;
        tick();
        tick();
        reset = 1'b0;
        check("rst_hi", 64'(hi_a), 64'(0));
        check("rst_lo", 64'(lo_a), 64'(0));
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_done", 64'(done_a), 64'(0));
        check("rst_dbz", 64'(dbz_a), 64'(0));

        // Signed multiply, busy length, then back-to-back MULTU in the done cycle
        issue_a(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        wait_idle_a(n);
        check("busy_len_a", 64'(n), 64'(33));
        issue_a(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_idle_a(n);
        issue_a(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 32'h0, 32'd6, 1'b0);
        wait_idle_a(n);

        // Divides
        issue_a(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
        wait_idle_a(n);
        issue_a(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_idle_a(n);
        issue_a(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0);
        wait_idle_a(n);
        issue_a(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 1'b0);
        wait_idle_a(n);
        issue_a(2'b11, 32'hFFFF_FFFF, 32'd10, 1'b1, 32'd5, 32'h1999_9999, 1'b0);
        wait_idle_a(n);

        // MTHI / MTLO, then divide by zero leaves them in place
        wdata_a = 32'h1234; hi_we_a = 1'b1;
        tick();
        hi_we_a = 1'b0; wdata_a = 32'h5678; lo_we_a = 1'b1;
        tick();
        lo_we_a = 1'b0;
        check("mthi", 64'(hi_a), 64'(32'h1234));
        check("mtlo", 64'(lo_a), 64'(32'h5678));
        issue_a(2'b10, 32'd9, 32'd0, 1'b1, 32'h1234, 32'h5678, 1'b1);
        wait_idle_a(n);

        // Cancel mid-divide; start/MTHI/MTLO while busy are ignored
        issue_a(2'b11, 32'h1000, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        start_a = 1'b1; op_a = 2'b00; a_a = 32'd1; b_a = 32'd1;
        hi_we_a = 1'b1; lo_we_a = 1'b1; wdata_a = 32'hDEAD_BEEF;
        repeat (3) tick();
        start_a = 1'b0; hi_we_a = 1'b0; lo_we_a = 1'b0;
        repeat (5) tick();
        check("busy_before_cancel", 64'(busy_a), 64'(1));
        cancel_a = 1'b1;
        tick();
        cancel_a = 1'b0;
        check("busy_after_cancel", 64'(busy_a), 64'(0));
        check("hi_after_cancel", 64'(hi_a), 64'(32'h1234));
        check("lo_after_cancel", 64'(lo_a), 64'(32'h5678));
        repeat (40) tick();
        check("hi_cancel_settled", 64'(hi_a), 64'(32'h1234));
        check("lo_cancel_settled", 64'(lo_a), 64'(32'h5678));

        // Reset in the middle of a multiply
        issue_a(2'b00, 32'd7, 32'd9, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("midrst_hi", 64'(hi_a), 64'(0));
        check("midrst_lo", 64'(lo_a), 64'(0));
        check("midrst_busy", 64'(busy_a), 64'(0));
        check("midrst_done", 64'(done_a), 64'(0));
        check("midrst_dbz", 64'(dbz_a), 64'(0));
        reset = 1'b0;
        issue_a(2'b00, 32'd2, 32'd3, 1'b1, 32'h0, 32'd6, 1'b0);
        wait_idle_a(n);

        // WIDTH=8 instance
        issue_b(2'b00, 8'h80, 8'h80, 8'h40, 8'h00);
        wait_idle_b(n);
        check("busy_len_b", 64'(n), 64'(9));
        issue_b(2'b10, 8'h80, 8'hFF, 8'h00, 8'h80);
        wait_idle_b(n);

        repeat (3) tick();
        check("pending_a", 64'(q_a.size()), 64'(0));
        check("pending_b", 64'(q_b.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
